// File: rtl/h_matrix_streamer.sv
// rtl/h_matrix_streamer.sv - windowed H-matrix row streamer with credit-checked output FIFO
//
// Purpose:
//   On an accepted start, reads rows cfg_base .. cfg_base+cfg_rows-1 from NUM_BANKS
//   external row ROMs that share one address and have ROM_LAT cycles of read latency.
//   Each returned row becomes one wide beat on a valid/ready stream, tagged with its
//   offset in the window and a last flag. ROM reads are only issued while the output
//   FIFO has a free slot for every read already in flight, so backpressure cannot
//   drop a row.
//
// Ports:
//   i_clk, i_rst     clock, synchronous active-low reset
//   i_start          one-cycle request to stream a window
//   i_cfg_base       first ROM row of the window (sampled on accepted start)
//   i_cfg_rows       number of rows in the window (sampled on accepted start)
//   o_busy           high from accepted start until done
//   o_done           one-cycle pulse after the last beat is accepted
//   o_err_cfg        one-cycle pulse when a start is rejected for an illegal window
//   o_rom_en         read strobe to all banks
//   o_rom_addr       shared bank address
//   i_rom_data       concatenated bank outputs, bank 0 in the LSBs
//   o_h_data         row beat
//   o_h_valid        beat valid
//   i_h_ready        downstream accept
//   o_h_row          row offset within the window
//   o_h_last         final beat of the window
module h_matrix_streamer #(
  parameter int NUM_BANKS = 27,
  parameter int ROW_W     = 162,
  parameter int DEPTH     = 64,
  parameter int ROM_LAT   = 1,
  localparam int AW       = $clog2(DEPTH) + 1,
  localparam int FIFO_D   = ROM_LAT + 2,
  localparam int DW       = NUM_BANKS * ROW_W
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [AW-1:0] i_cfg_base,
  input  logic [AW-1:0] i_cfg_rows,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err_cfg,
  output logic          o_rom_en,
  output logic [AW-2:0] o_rom_addr,
  input  logic [DW-1:0] i_rom_data,
  output logic [DW-1:0] o_h_data,
  output logic          o_h_valid,
  input  logic          i_h_ready,
  output logic [AW-1:0] o_h_row,
  output logic          o_h_last
);
  localparam int PW = $clog2(FIFO_D);
  localparam int CW = $clog2(FIFO_D + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;
  state_t r_state, w_state_nxt;

  logic [AW-1:0]      r_base, r_rows, r_issued;
  logic [ROM_LAT-1:0] r_vld_sr;
  logic [AW-1:0]      r_off_sr [ROM_LAT];
  logic [CW-1:0]      r_inflight, r_count;
  logic [PW-1:0]      r_wptr, r_rptr;
  logic [DW-1:0]      r_mem_data [FIFO_D];
  logic [AW-1:0]      r_mem_row  [FIFO_D];
  logic [FIFO_D-1:0]  r_mem_last;
  logic               r_done, r_err;

  logic [AW:0]   w_cfg_end;
  logic [CW:0]   w_used;
  logic [AW-1:0] w_issued_inc, w_push_off;
  logic          w_cfg_bad, w_start_ok, w_accept, w_credit_ok;
  logic          w_issue, w_push, w_pop, w_head_last;

  // Range check in AW+1 bits so base+rows cannot wrap before comparison.
  assign w_cfg_end  = {1'b0, i_cfg_base} + {1'b0, i_cfg_rows};
  assign w_cfg_bad  = (i_cfg_rows == '0) || (w_cfg_end > (AW+1)'(DEPTH));
  // A start landing in the done cycle is dropped so a window never overlaps its own done.
  assign w_start_ok = (r_state == S_IDLE) && i_start && !r_done;
  assign w_accept   = w_start_ok && !w_cfg_bad;

  // Every issued read owns a FIFO slot from issue until it is popped.
  assign w_used      = {1'b0, r_count} + {1'b0, r_inflight};
  assign w_credit_ok = w_used < (CW+1)'(FIFO_D);

  assign w_issued_inc = r_issued + AW'(1);
  assign w_push       = r_vld_sr[ROM_LAT-1];
  assign w_push_off   = r_off_sr[ROM_LAT-1];
  assign w_pop        = o_h_valid && i_h_ready;
  assign w_head_last  = r_mem_last[r_rptr];

  // FSM: state register
  always_ff @(posedge i_clk) begin
    if (!i_rst) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
      S_RUN:   if (w_issue && (w_issued_inc == r_rows)) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_pop && w_head_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    o_busy     = (r_state != S_IDLE);
    w_issue    = (r_state == S_RUN) && (r_issued < r_rows) && w_credit_ok;
    o_rom_en   = w_issue;
    o_rom_addr = w_issue ? (AW-1)'(r_base + r_issued) : '0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_base     <= '0;
      r_rows     <= '0;
      r_issued   <= '0;
      r_vld_sr   <= '0;
      r_inflight <= '0;
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= (r_state == S_DRAIN) && w_pop && w_head_last;
      r_err  <= w_start_ok && w_cfg_bad;
      if (w_accept) begin
        r_base   <= i_cfg_base;
        r_rows   <= i_cfg_rows;
        r_issued <= '0;
      end else if (w_issue) begin
        r_issued <= w_issued_inc;
      end
      r_vld_sr[0] <= w_issue;
      for (int i = 1; i < ROM_LAT; i++) r_vld_sr[i] <= r_vld_sr[i-1];
      case ({w_issue, w_push})
        2'b10:   r_inflight <= r_inflight + CW'(1);
        2'b01:   r_inflight <= r_inflight - CW'(1);
        default: r_inflight <= r_inflight;
      endcase
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_push) r_wptr <= (r_wptr == PW'(FIFO_D - 1)) ? '0 : r_wptr + PW'(1);
      if (w_pop)  r_rptr <= (r_rptr == PW'(FIFO_D - 1)) ? '0 : r_rptr + PW'(1);
    end
  end

  // Datapath storage: contents are qualified by r_vld_sr / r_count, so no reset needed.
  always_ff @(posedge i_clk) begin
    r_off_sr[0] <= r_issued;
    for (int i = 1; i < ROM_LAT; i++) r_off_sr[i] <= r_off_sr[i-1];
    if (w_push) begin
      r_mem_data[r_wptr] <= i_rom_data;
      r_mem_row[r_wptr]  <= w_push_off;
      r_mem_last[r_wptr] <= (w_push_off == r_rows - AW'(1));
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) assert (!(w_push && !w_pop && (r_count == CW'(FIFO_D))));
  end

  // Head fields are forced to zero when empty so idle outputs are clean.
  assign o_h_valid = (r_count != '0);
  assign o_h_data  = o_h_valid ? r_mem_data[r_rptr] : '0;
  assign o_h_row   = o_h_valid ? r_mem_row[r_rptr] : '0;
  assign o_h_last  = o_h_valid && w_head_last;
  assign o_done    = r_done;
  assign o_err_cfg = r_err;

endmodule

// File: tb/tb_h_matrix_streamer.sv
// tb/tb_h_matrix_streamer.sv - self-checking bench for h_matrix_streamer
module tb_h_matrix_streamer;
  localparam int NUM_BANKS = 27;
  localparam int ROW_W     = 162;
  localparam int DEPTH     = 64;
  localparam int AW        = $clog2(DEPTH) + 1;
  localparam int DW        = NUM_BANKS * ROW_W;
  localparam int LAT0      = 1;
  localparam int LAT1      = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    start, busy, done, err_cfg, rom_en, h_valid, h_ready, h_last;
  logic [AW-1:0] cfg_base [2];
  logic [AW-1:0] cfg_rows [2];
  logic [AW-1:0] h_row    [2];
  logic [AW-2:0] rom_addr [2];
  logic [DW-1:0] rom_data [2];
  logic [DW-1:0] h_data   [2];
  logic [DW-1:0] rom      [DEPTH];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? LAT0 : LAT1;
    logic [DW-1:0] pipe [LAT];
    always @(posedge clk) begin
      pipe[0] <= rom_en[g] ? rom[rom_addr[g]] : '0;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign rom_data[g] = pipe[LAT-1];

    h_matrix_streamer #(
      .NUM_BANKS(NUM_BANKS), .ROW_W(ROW_W), .DEPTH(DEPTH), .ROM_LAT(LAT)
    ) u_dut (
      .i_clk(clk), .i_rst(rst), .i_start(start[g]),
      .i_cfg_base(cfg_base[g]), .i_cfg_rows(cfg_rows[g]),
      .o_busy(busy[g]), .o_done(done[g]), .o_err_cfg(err_cfg[g]),
      .o_rom_en(rom_en[g]), .o_rom_addr(rom_addr[g]), .i_rom_data(rom_data[g]),
      .o_h_data(h_data[g]), .o_h_valid(h_valid[g]), .i_h_ready(h_ready[g]),
      .o_h_row(h_row[g]), .o_h_last(h_last[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input int expv);
    logic [31:0] e;
    e = expv;
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
    end
  endtask

  task automatic chk_data(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed[63:0]=%h expected[63:0]=%h", tag, obs[63:0], expv[63:0]);
    end
  endtask

  task automatic check_zero(input bit k, input string tag);
    chk({tag, " busy"},     32'(busy[k]), 0);
    chk({tag, " done"},     32'(done[k]), 0);
    chk({tag, " err_cfg"},  32'(err_cfg[k]), 0);
    chk({tag, " rom_en"},   32'(rom_en[k]), 0);
    chk({tag, " rom_addr"}, 32'(rom_addr[k]), 0);
    chk({tag, " h_valid"},  32'(h_valid[k]), 0);
    chk({tag, " h_last"},   32'(h_last[k]), 0);
    chk({tag, " h_row"},    32'(h_row[k]), 0);
    chk_data({tag, " h_data"}, h_data[k], '0);
  endtask

  task automatic bad_cfg(input bit k, input int base, input int rows);
    cfg_base[k] = AW'(base);
    cfg_rows[k] = AW'(rows);
    start[k] = 1'b1;
    @(posedge clk); #1;
    start[k] = 1'b0;
    chk($sformatf("badcfg b%0d r%0d err_pulse", base, rows), 32'(err_cfg[k]), 1);
    chk($sformatf("badcfg b%0d r%0d busy", base, rows), 32'(busy[k]), 0);
    chk($sformatf("badcfg b%0d r%0d rom_en", base, rows), 32'(rom_en[k]), 0);
    @(posedge clk); #1;
    chk($sformatf("badcfg b%0d r%0d err_once", base, rows), 32'(err_cfg[k]), 0);
    chk($sformatf("badcfg b%0d r%0d busy2", base, rows), 32'(busy[k]), 0);
    chk($sformatf("badcfg b%0d r%0d rom_en2", base, rows), 32'(rom_en[k]), 0);
  endtask

  // Cycle-level model: a read may issue only while fewer than ROM_LAT+2 rows are
  // outstanding (issued but not yet accepted); row i becomes visible ROM_LAT+1
  // cycles after its read, in order; done follows the accepted last row by one cycle.
  task automatic run_window(input bit k, input int base, input int rows, input bit rand_ready,
                            input int abort_after, input bit poke_start);
    int lat, fifo_d, issued, popped, cyc, last_pop, first_v;
    int issue_cyc[$];
    bit exp_en, exp_v, exp_busy, exp_done, rdy, finished;
    string tg;
    lat = (k == 1'b0) ? LAT0 : LAT1;
    fifo_d = lat + 2;
    issued = 0; popped = 0; last_pop = -1; first_v = -1; finished = 0;
    cfg_base[k] = AW'(base);
    cfg_rows[k] = AW'(rows);
    start[k] = 1'b1;
    h_ready[k] = 1'b1;
    @(posedge clk); #1;
    start[k] = 1'b0;
    for (cyc = 1; cyc < 400; cyc++) begin
      tg = $sformatf("k%0d b%0d r%0d c%0d", k, base, rows, cyc);
      if (abort_after >= 0 && popped == abort_after) begin
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check_zero(k, {tg, " abort"});
        for (int i = 0; i < lat + 3; i++) begin
          @(posedge clk); #1;
          chk({tg, " post_abort h_valid"}, 32'(h_valid[k]), 0);
          chk({tg, " post_abort rom_en"}, 32'(rom_en[k]), 0);
          chk({tg, " post_abort done"}, 32'(done[k]), 0);
        end
        finished = 1;
        break;
      end
      exp_done = (last_pop >= 0) && (cyc == last_pop + 1);
      exp_busy = (last_pop < 0);
      chk({tg, " busy"}, 32'(busy[k]), int'(exp_busy));
      chk({tg, " done"}, 32'(done[k]), int'(exp_done));
      chk({tg, " err_cfg"}, 32'(err_cfg[k]), 0);
      exp_en = exp_busy && (issued < rows) && ((issued - popped) < fifo_d);
      chk({tg, " rom_en"}, 32'(rom_en[k]), int'(exp_en));
      if (exp_en) begin
        chk({tg, " rom_addr"}, 32'(rom_addr[k]), base + issued);
        issue_cyc.push_back(cyc);
        issued++;
      end
      exp_v = (popped < issue_cyc.size()) && (issue_cyc[popped] + lat + 1 <= cyc);
      chk({tg, " h_valid"}, 32'(h_valid[k]), int'(exp_v));
      if (exp_v) begin
        chk_data({tg, " h_data"}, h_data[k], rom[6'(base + popped)]);
        chk({tg, " h_row"}, 32'(h_row[k]), popped);
        chk({tg, " h_last"}, 32'(h_last[k]), int'(popped == rows - 1));
        if (first_v < 0) first_v = cyc;
      end
      rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      h_ready[k] = rdy;
      start[k] = poke_start && (cyc == 4 || exp_done);
      if (poke_start && cyc == 4) begin
        cfg_base[k] = '0;
        cfg_rows[k] = AW'(1);
      end
      if (exp_v && rdy) begin
        if (popped == rows - 1) last_pop = cyc;
        popped++;
      end
      if (exp_done) begin
        finished = 1;
        break;
      end
      @(posedge clk); #1;
    end
    chk($sformatf("k%0d b%0d r%0d window_finished", k, base, rows), 32'(finished), 1);
    if (abort_after < 0) begin
      @(posedge clk); #1;
      start[k] = 1'b0;
      tg = $sformatf("k%0d b%0d r%0d after_done", k, base, rows);
      chk({tg, " busy"}, 32'(busy[k]), 0);
      chk({tg, " done"}, 32'(done[k]), 0);
      chk({tg, " rom_en"}, 32'(rom_en[k]), 0);
      chk({tg, " h_valid"}, 32'(h_valid[k]), 0);
      chk({tg, " err_cfg"}, 32'(err_cfg[k]), 0);
      if (!rand_ready) begin
        chk({tg, " first_valid_cycle"}, 32'(first_v), lat + 2);
        chk({tg, " last_beat_cycle"}, 32'(last_pop), lat + 1 + rows);
      end
    end
    h_ready[k] = 1'b1;
  endtask

  initial begin
    int rows, base;
    rst = 1'b0;
    start = '0;
    h_ready = '1;
    cfg_base[0] = '0; cfg_base[1] = '0;
    cfg_rows[0] = '0; cfg_rows[1] = '0;
    for (int a = 0; a < DEPTH; a++) begin
      logic [DW-1:0] w;
      w = '0;
      for (int j = 0; j < DW; j += 32) w = {w[DW-33:0], 32'($urandom)};
      rom[a] = w;
    end
    repeat (2) @(posedge clk);
    #1;
    check_zero(1'b0, "reset k0");
    check_zero(1'b1, "reset k1");
    rst = 1'b1;
    @(posedge clk); #1;

    run_window(1'b0, 0, 19, 1'b0, -1, 1'b0);
    run_window(1'b0, 19, 8, 1'b0, -1, 1'b0);
    run_window(1'b1, 0, 19, 1'b1, -1, 1'b0);
    run_window(1'b1, 0, 19, 1'b0, -1, 1'b0);
    run_window(1'b0, 56, 8, 1'b1, -1, 1'b0);
    run_window(1'b1, 63, 1, 1'b0, -1, 1'b0);
    for (int n = 0; n < 4; n++) begin
      rows = int'($urandom_range(1, 24));
      base = int'($urandom_range(0, DEPTH - rows));
      run_window(1'(n), base, rows, 1'b1, -1, 1'b0);
    end

    bad_cfg(1'b0, 0, 0);
    bad_cfg(1'b0, 60, 5);
    bad_cfg(1'b1, 64, 1);

    run_window(1'b0, 0, 19, 1'b0, 7, 1'b0);
    run_window(1'b0, 0, 19, 1'b0, -1, 1'b0);
    run_window(1'b1, 0, 19, 1'b1, 5, 1'b0);
    run_window(1'b1, 0, 19, 1'b1, -1, 1'b0);

    run_window(1'b1, 5, 12, 1'b1, -1, 1'b1);
    run_window(1'b0, 30, 10, 1'b0, -1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
